// File: rtl/fir_tdm_mac_if.sv
// rtl/fir_tdm_mac_if.sv - sample/coefficient/output bundle for the TDM FIR MAC
interface fir_tdm_mac_if #(
    parameter int FIR_LEN  = 21,
    parameter int NB_COEFF = 8,
    parameter int NB_IN    = 18,
    parameter int NB_OUT   = 18,
    parameter int N_CH     = 2
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ADDR_W = $clog2(FIR_LEN);

    logic                       i_en;
    logic                       i_valid;
    logic signed [NB_IN-1:0]    i_sample;
    logic [CH_W-1:0]            i_ch;
    logic                       o_ready;
    logic                       i_coeff_we;
    logic [ADDR_W-1:0]          i_coeff_addr;
    logic signed [NB_COEFF-1:0] i_coeff_data;
    logic signed [NB_OUT-1:0]   o_sample;
    logic [CH_W-1:0]            o_ch;
    logic                       o_valid;
    logic                       o_sat;

    modport slave (
        input  i_en, i_valid, i_sample, i_ch, i_coeff_we, i_coeff_addr, i_coeff_data,
        output o_ready, o_sample, o_ch, o_valid, o_sat
    );

    modport master (
        output i_en, i_valid, i_sample, i_ch, i_coeff_we, i_coeff_addr, i_coeff_data,
        input  o_ready, o_sample, o_ch, o_valid, o_sat
    );
endinterface

// File: rtl/fir_tdm_mac.sv
// rtl/fir_tdm_mac.sv - multi-channel FIR sharing one MAC, rounded and saturated output
module fir_tdm_mac #(
    parameter int FIR_LEN   = 21,
    parameter int NB_COEFF  = 8,
    parameter int NBF_COEFF = 7,
    parameter int NB_IN     = 18,
    parameter int NBF_IN    = 15,
    parameter int NB_OUT    = 18,
    parameter int NBF_OUT   = 15,
    parameter int N_CH      = 2
) (
    input logic          i_clock,
    input logic          i_reset,
    fir_tdm_mac_if.slave bus
);
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ADDR_W  = $clog2(FIR_LEN);
    localparam int NB_PROD = NB_IN + NB_COEFF;
    localparam int NB_ACC  = NB_PROD + $clog2(FIR_LEN);
    localparam int NB_EXT  = NB_ACC + 1;
    localparam int SH      = NBF_IN + NBF_COEFF - NBF_OUT;

    localparam logic [ADDR_W-1:0]        LAST     = ADDR_W'(FIR_LEN - 1);
    localparam logic signed [NB_EXT-1:0] RND_HALF = NB_EXT'(1) <<< (SH - 1);
    localparam logic signed [NB_EXT-1:0] OUT_MAX  = NB_EXT'((2 ** (NB_OUT - 1)) - 1);
    localparam logic signed [NB_EXT-1:0] OUT_MIN  = NB_EXT'(-(2 ** (NB_OUT - 1)));

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          k_q, k_d;
    logic [ADDR_W-1:0]          rd_q, rd_d;
    logic [CH_W-1:0]            cur_ch_q, cur_ch_d;
    logic signed [NB_ACC-1:0]   acc_q, acc_d;
    logic signed [NB_OUT-1:0]   o_sample_q, o_sample_d;
    logic [CH_W-1:0]            o_ch_q, o_ch_d;
    logic                       o_sat_q, o_sat_d;
    logic                       o_valid_q, o_valid_d;

    logic signed [NB_IN-1:0]    dl_q [N_CH][FIR_LEN];
    logic signed [NB_COEFF-1:0] coef_q [FIR_LEN];
    logic [ADDR_W-1:0]          wptr_q [N_CH];

    logic                       ready;
    logic                       ch_ok;
    logic                       accept;
    logic                       coef_wr;
    logic signed [NB_PROD-1:0]  prod;
    logic signed [NB_ACC-1:0]   prod_ext;
    logic signed [NB_EXT-1:0]   rnd_sum;
    logic signed [NB_EXT-1:0]   rnd_sh;
    logic signed [NB_OUT-1:0]   sat_val;
    logic                       sat_flag;

    // A coefficient write owns the IDLE cycle, so it blocks a sample accept.
    assign ready   = (state_q == S_IDLE) && bus.i_en && !bus.i_coeff_we;
    assign ch_ok   = int'(bus.i_ch) < N_CH;
    assign accept  = bus.i_valid && ready && ch_ok;
    assign coef_wr = (state_q == S_IDLE) && bus.i_coeff_we && (int'(bus.i_coeff_addr) < FIR_LEN);

    // rd_q walks backwards through the circular line: x[n-k] pairs with h[k].
    assign prod     = dl_q[cur_ch_q][rd_q] * coef_q[k_q];
    assign prod_ext = {{(NB_ACC - NB_PROD){prod[NB_PROD-1]}}, prod};

    // Round half up, then clamp to the output range.
    always_comb begin
        rnd_sum  = $signed({acc_q[NB_ACC-1], acc_q}) + RND_HALF;
        rnd_sh   = rnd_sum >>> SH;
        sat_flag = 1'b0;
        sat_val  = rnd_sh[NB_OUT-1:0];
        if (rnd_sh > OUT_MAX) begin
            sat_val  = OUT_MAX[NB_OUT-1:0];
            sat_flag = 1'b1;
        end else if (rnd_sh < OUT_MIN) begin
            sat_val  = OUT_MIN[NB_OUT-1:0];
            sat_flag = 1'b1;
        end
    end

    // Next-state and datapath control for IDLE -> MAC -> OUT.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        rd_d       = rd_q;
        cur_ch_d   = cur_ch_q;
        acc_d      = acc_q;
        o_sample_d = o_sample_q;
        o_ch_d     = o_ch_q;
        o_sat_d    = o_sat_q;
        o_valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_MAC;
                    k_d      = '0;
                    rd_d     = wptr_q[bus.i_ch];
                    cur_ch_d = bus.i_ch;
                    acc_d    = '0;
                end
            end
            S_MAC: begin
                if (bus.i_en) begin
                    acc_d = acc_q + prod_ext;
                    rd_d  = (rd_q == '0) ? LAST : rd_q - ADDR_W'(1);
                    if (k_q == LAST) begin
                        k_d     = '0;
                        state_d = S_OUT;
                    end else begin
                        k_d = k_q + ADDR_W'(1);
                    end
                end
            end
            S_OUT: begin
                if (bus.i_en) begin
                    o_sample_d = sat_val;
                    o_ch_d     = cur_ch_q;
                    o_sat_d    = sat_flag;
                    o_valid_d  = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers; reset abandons any partial computation.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            rd_q       <= '0;
            cur_ch_q   <= '0;
            acc_q      <= '0;
            o_sample_q <= '0;
            o_ch_q     <= '0;
            o_sat_q    <= 1'b0;
            o_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            rd_q       <= rd_d;
            cur_ch_q   <= cur_ch_d;
            acc_q      <= acc_d;
            o_sample_q <= o_sample_d;
            o_ch_q     <= o_ch_d;
            o_sat_q    <= o_sat_d;
            o_valid_q  <= o_valid_d;
        end
    end

    // Per-channel delay lines and the shared coefficient bank.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int c = 0; c < N_CH; c++) begin
                wptr_q[c] <= '0;
                for (int t = 0; t < FIR_LEN; t++) begin
                    dl_q[c][t] <= '0;
                end
            end
            for (int t = 0; t < FIR_LEN; t++) begin
                coef_q[t] <= '0;
            end
        end else begin
            if (accept) begin
                dl_q[bus.i_ch][wptr_q[bus.i_ch]] <= bus.i_sample;
                wptr_q[bus.i_ch] <= (wptr_q[bus.i_ch] == LAST) ? '0
                                                                 : wptr_q[bus.i_ch] + ADDR_W'(1);
            end
            if (coef_wr) begin
                coef_q[bus.i_coeff_addr] <= bus.i_coeff_data;
            end
        end
    end

    assign bus.o_ready  = ready;
    assign bus.o_sample = o_sample_q;
    assign bus.o_ch     = o_ch_q;
    assign bus.o_sat    = o_sat_q;
    assign bus.o_valid  = o_valid_q;
endmodule

// File: tb/tb_fir_tdm_mac.sv
// tb/tb_fir_tdm_mac.sv - scoreboard bench for fir_tdm_mac
module tb_fir_tdm_mac;
    localparam int FIR_LEN   = 21;
    localparam int NB_COEFF  = 8;
    localparam int NBF_COEFF = 7;
    localparam int NB_IN     = 18;
    localparam int NBF_IN    = 15;
    localparam int NB_OUT    = 18;
    localparam int NBF_OUT   = 15;
    localparam int N_CH      = 2;
    localparam int CH_W      = 1;
    localparam int ADDR_W    = $clog2(FIR_LEN);
    localparam int LAT       = FIR_LEN + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_tdm_mac_if #(.FIR_LEN(FIR_LEN), .NB_COEFF(NB_COEFF), .NB_IN(NB_IN),
                     .NB_OUT(NB_OUT), .N_CH(N_CH)) bus ();

    fir_tdm_mac #(
        .FIR_LEN(FIR_LEN), .NB_COEFF(NB_COEFF), .NBF_COEFF(NBF_COEFF),
        .NB_IN(NB_IN), .NBF_IN(NBF_IN), .NB_OUT(NB_OUT), .NBF_OUT(NBF_OUT), .N_CH(N_CH)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    typedef struct {
        int sample;
        int ch;
        int sat;
        int lat;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Monitor: every output strobe is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: sample=%0d ch=%0d at cycle %0d",
                             int'(bus.o_sample), int'(bus.o_ch), cyc);
                end else begin
                    e = sb.pop_front();
                    if (int'(bus.o_sample) != e.sample || int'(bus.o_ch) != e.ch ||
                        int'(bus.o_sat) != e.sat || (cyc - e.acc_cyc) != e.lat) begin
                        n_fail++;
                        $display("FAIL output: got sample=%0d ch=%0d sat=%0d lat=%0d expected sample=%0d ch=%0d sat=%0d lat=%0d",
                                 int'(bus.o_sample), int'(bus.o_ch), int'(bus.o_sat), cyc - e.acc_cyc,
                                 e.sample, e.ch, e.sat, e.lat);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int w = 0;
        #1;
        while (bus.o_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 200) check("wait_idle_timeout", 0, 1);
    endtask

    task automatic wcoef(input int addr, input int data);
        wait_idle();
        bus.i_coeff_we   = 1'b1;
        bus.i_coeff_addr = ADDR_W'(addr);
        bus.i_coeff_data = NB_COEFF'(data);
        @(negedge clk);
        bus.i_coeff_we   = 1'b0;
    endtask

    // Presents a sample until the handshake completes; returns at the negedge after accept.
    task automatic send(input int s, input int ch, input int es, input int esat,
                        input int lat, input bit push);
        int w = 0;
        exp_t e;
        bus.i_valid  = 1'b1;
        bus.i_sample = NB_IN'(s);
        bus.i_ch     = CH_W'(ch);
        #1;
        while (bus.o_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 200) begin
            check("accept_timeout", 0, 1);
        end else begin
            e.sample  = es;
            e.ch      = ch;
            e.sat     = esat;
            e.lat     = lat;
            e.acc_cyc = cyc + 1;
            if (push) sb.push_back(e);
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.i_en         = 1'b1;
        bus.i_valid      = 1'b0;
        bus.i_sample     = '0;
        bus.i_ch         = '0;
        bus.i_coeff_we   = 1'b0;
        bus.i_coeff_addr = '0;
        bus.i_coeff_data = '0;
        repeat (2) @(negedge clk);
        check("rst_o_sample", int'(bus.o_sample), 0);
        check("rst_o_valid", int'(bus.o_valid), 0);
        check("rst_o_ch", int'(bus.o_ch), 0);
        check("rst_o_sat", int'(bus.o_sat), 0);
        rst = 1'b0;
        #1;
        check("rst_o_ready", int'(bus.o_ready), 1);
        @(negedge clk);

        // Gain 0.5 on tap 0
        wcoef(0, 64);
        send(32768, 0, 16384, 0, LAT, 1'b1);
        drain();

        // Impulse response on ch0 with interleaved silent ch1
        do_reset();
        for (int k = 0; k < FIR_LEN; k++) wcoef(k, k + 1);
        for (int n = 0; n < FIR_LEN; n++) begin
            send((n == 0) ? 32768 : 0, 0, 256 * (n + 1), 0, LAT, 1'b1);
            send(0, 1, 0, 0, LAT, 1'b1);
        end
        drain();

        // Rounding with h[0] = 1
        do_reset();
        wcoef(0, 1);
        send(64, 0, 1, 0, LAT, 1'b1);
        send(63, 0, 0, 0, LAT, 1'b1);
        send(-64, 0, 0, 0, LAT, 1'b1);
        send(-65, 0, -1, 0, LAT, 1'b1);
        drain();

        // Sample held and coefficient write attempted during MAC
        send(64, 0, 1, 0, LAT, 1'b1);
        bus.i_valid      = 1'b1;
        bus.i_sample     = NB_IN'(-65);
        bus.i_coeff_we   = 1'b1;
        bus.i_coeff_addr = '0;
        bus.i_coeff_data = NB_COEFF'(100);
        #1;
        check("mac_ready_low", int'(bus.o_ready), 0);
        @(negedge clk);
        bus.i_coeff_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mac_ready_low", int'(bus.o_ready), 0);
            @(negedge clk);
        end
        send(-65, 0, -1, 0, LAT, 1'b1);

        // Coefficient write and valid together in IDLE: write wins the cycle
        wait_idle();
        bus.i_coeff_we   = 1'b1;
        bus.i_coeff_addr = '0;
        bus.i_coeff_data = NB_COEFF'(2);
        bus.i_valid      = 1'b1;
        bus.i_sample     = NB_IN'(128);
        bus.i_ch         = '0;
        #1;
        check("we_blocks_ready", int'(bus.o_ready), 0);
        @(negedge clk);
        bus.i_coeff_we = 1'b0;
        send(128, 0, 2, 0, LAT, 1'b1);

        // Five disabled MAC cycles stretch latency by five
        send(64, 0, 1, 0, LAT + 5, 1'b1);
        repeat (2) @(negedge clk);
        bus.i_en = 1'b0;
        repeat (5) @(negedge clk);
        bus.i_en = 1'b1;
        drain();

        // Positive saturation
        do_reset();
        for (int k = 0; k < FIR_LEN; k++) wcoef(k, 127);
        send(131071, 0, 130047, 0, LAT, 1'b1);
        send(131071, 0, 131071, 1, LAT, 1'b1);
        send(131071, 0, 131071, 1, LAT, 1'b1);
        drain();

        // Negative saturation
        do_reset();
        for (int k = 0; k < FIR_LEN; k++) wcoef(k, 127);
        send(-131072, 0, -130048, 0, LAT, 1'b1);
        send(-131072, 0, -131072, 1, LAT, 1'b1);
        send(-131072, 0, -131072, 1, LAT, 1'b1);
        drain();

        // Reset in the middle of MAC discards the computation and the coefficients
        send(64, 0, 0, 0, LAT, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_o_valid", int'(bus.o_valid), 0);
        check("midrst_o_sample", int'(bus.o_sample), 0);
        check("midrst_o_sat", int'(bus.o_sat), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_idle_ready", int'(bus.o_ready), 1);
        @(negedge clk);
        send(32768, 0, 0, 0, LAT, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
